// File: rtl/decode_dense_pipe.sv
// ============================================================================
//  Module   : decode_dense_pipe
//  Brief    : Elastic valid/ready pipeline for the decoded dense-layer command
//             bundle, with bubble collapsing, backpressure and sync flush.
//             Optional occupancy counter: DECODE_DENSE_PIPE_COUNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_dense_pipe #(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int act_type_size   = 4,
  parameter int dense_type_size = 4,
  parameter int cost_type_size  = 8,
  parameter int depth           = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [act_type_size-1:0]      act_type,
  input  logic [dense_type_size-1:0]    dense_type,
  input  logic [cost_type_size-1:0]     cost_type,
  input  logic [data_size*size-1:0]     w,
  input  logic [data_size*size-1:0]     x,
  input  logic [data_size*size-1:0]     label_in,
  input  logic [31:0]                   w_layer_index,
  input  logic [31:0]                   w_row_index,
  input  logic                          is_update,
  input  logic                          load_w,
  input  logic                          backprop_cost,
  input  logic                          is_cost_layer,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [act_type_size-1:0]      act_type_out,
  output logic [dense_type_size-1:0]    dense_type_out,
  output logic [cost_type_size-1:0]     cost_type_out,
  output logic [data_size*size-1:0]     w_out,
  output logic [data_size*size-1:0]     x_out,
  output logic [data_size*size-1:0]     label_out,
  output logic [31:0]                   w_layer_index_out,
  output logic [31:0]                   w_row_index_out,
  output logic                          is_update_out,
  output logic                          load_w_out,
  output logic                          backprop_cost_out,
  output logic                          is_cost_layer_out,
  output logic [$clog2(depth+1)-1:0]    count
);

  localparam int c_vec_w   = data_size * size;
  localparam int c_count_w = $clog2(depth + 1);

  typedef struct packed {
    logic [act_type_size-1:0]   act_type;
    logic [dense_type_size-1:0] dense_type;
    logic [cost_type_size-1:0]  cost_type;
    logic [c_vec_w-1:0]         w;
    logic [c_vec_w-1:0]         x;
    logic [c_vec_w-1:0]         label;
    logic [31:0]                w_layer_index;
    logic [31:0]                w_row_index;
    logic                       is_update;
    logic                       load_w;
    logic                       backprop_cost;
    logic                       is_cost_layer;
  } payload_t;

  payload_t         w_in_pkt;
  payload_t         w_last;
  payload_t         r_p [depth];
  logic [depth-1:0] r_v;
  logic [depth:0]   w_r;
  logic [depth-1:0] w_load;

  assign w_in_pkt = '{act_type:      act_type,
                      dense_type:    dense_type,
                      cost_type:     cost_type,
                      w:             w,
                      x:             x,
                      label:         label_in,
                      w_layer_index: w_layer_index,
                      w_row_index:   w_row_index,
                      is_update:     is_update,
                      load_w:        load_w,
                      backprop_cost: backprop_cost,
                      is_cost_layer: is_cost_layer};

  // Ready ripples back from the sink; an empty stage is always ready.
  assign w_r[depth] = out_ready;
  assign in_ready   = w_r[0] && !flush;

  generate
    for (genvar k = 0; k < depth; k++) begin : g_stage
      logic     r_vld;
      payload_t r_pay;
      payload_t w_src;

      assign w_r[k] = !r_vld || w_r[k+1];

      if (k == 0) begin : g_head
        assign w_load[k] = in_valid && in_ready;
        assign w_src     = w_in_pkt;
      end else begin : g_body
        assign w_load[k] = r_v[k-1] && w_r[k] && !flush;
        assign w_src     = r_p[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_pay <= '0;
        end else begin
          if (flush) begin
            r_vld <= 1'b0;
          end else begin
            r_vld <= w_load[k] || (r_vld && !w_r[k+1]);
          end
          if (w_load[k]) begin
            r_pay <= w_src;
          end
        end
      end

      assign r_v[k] = r_vld;
      assign r_p[k] = r_pay;
    end
  endgenerate

  assign out_valid = r_v[depth-1];
  assign w_last    = r_p[depth-1];

  assign act_type_out      = w_last.act_type;
  assign dense_type_out    = w_last.dense_type;
  assign cost_type_out     = w_last.cost_type;
  assign w_out             = w_last.w;
  assign x_out             = w_last.x;
  assign label_out         = w_last.label;
  assign w_layer_index_out = w_last.w_layer_index;
  assign w_row_index_out   = w_last.w_row_index;
  assign is_update_out     = w_last.is_update;
  assign load_w_out        = w_last.load_w;
  assign backprop_cost_out = w_last.backprop_cost;
  assign is_cost_layer_out = w_last.is_cost_layer;

`ifdef DECODE_DENSE_PIPE_COUNT_EN
  logic [c_count_w-1:0] r_count;
  logic                 w_acc;
  logic                 w_xfer;

  assign w_acc  = in_valid && in_ready;
  assign w_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_acc, w_xfer})
        2'b10:   r_count <= r_count + c_count_w'(1);
        2'b01:   r_count <= r_count - c_count_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

  // Counter must always agree with the stage occupancy bits.
  a_count_matches_v : assert property (@(posedge clk) disable iff (rst)
    r_count == c_count_w'($countones(r_v)));
`else
  assign count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/decode_dense_pipe.md
# decode_dense_pipe

Parametrised, elastic pipeline register for the decoded dense-layer command bundle: activation, dense and cost type codes, weight row, layer/row indices, update/load/backprop flags, input vector, label vector and cost-layer flag. It sits between the instruction decoder and the dense/cost datapath. It replaces a fixed one-cycle delay with `depth` stages, adding a valid/ready handshake, bubble collapsing, backpressure and a synchronous flush. All fields of one command always travel together in the same stage.

## Interface
- `size`, 3: vector elements per `w`, `x` and `label`.
- `data_size`, 16: bits per vector element.
- `act_type_size`, 4: activation code width.
- `dense_type_size`, 4: dense code width.
- `cost_type_size`, 8: cost code width.
- `depth`, 2: number of register stages; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `flush`  in  1  synchronous pipeline clear.
- `in_valid`  in  1  upstream command valid.
- `in_ready`  out  1  pipeline accepts the command this cycle.
- `act_type` / `dense_type` / `cost_type`  in  act_type_size / dense_type_size / cost_type_size  type codes.
- `w`, `x`, `label_in`  in  data_size*size each  weight row, input vector, label vector.
- `w_layer_index`, `w_row_index`  in  32 each  weight addressing.
- `is_update`, `load_w`, `backprop_cost`, `is_cost_layer`  in  1 each  control flags.
- `out_valid`  out  1  the last stage holds a command.
- `out_ready`  in  1  downstream accepts.
- `*_out` (one per input field, `label_out` for `label_in`)  out  same width as the matching input  payload of the last stage.
- `count`  out  $clog2(depth+1)  number of occupied stages.

## Operation
- Stage k (0..depth-1) holds `v[k]` and `p[k]`. Stage depth-1 drives `out_valid` and all `*_out` ports.
- Ready chain: `r[depth] = out_ready`, `r[k] = !v[k] || r[k+1]`, `in_ready = r[0] && !flush`. The chain is combinational, so bubbles collapse within a cycle.
- Stage 0 loads when `in_valid && in_ready`. Stage k>0 loads from k-1 when `v[k-1] && r[k]`.
- A stage whose content moves on and receives nothing next clears its `v`.
- `p[k]` is written only on a load. A stalled stage (`v[k] && !r[k+1]`) holds its payload bit-exact.
- `flush` clears every `v[k]` on the next edge. It overrides any load and any output transfer in the same cycle. `in_ready` is 0 while `flush` is high. Payload registers are left unchanged by `flush`.
- Output transfer occurs when `out_valid && out_ready`. `out_valid` never deasserts without a transfer, a flush or a reset.
- Ordering is strict FIFO. There is no reordering, duplication or drop except through `flush`.
- `count` equals the number of set `v[k]` bits, range 0..depth.

## Timing
- Reset: all `v` = 0, all payload = 0, `out_valid` = 0, all `*_out` = 0, `count` = 0. `in_ready` is 1 during reset because it follows the ready chain with `flush` low.
- Latency: a command accepted at edge N appears at the output after edge N+depth-1 when there is no stall. With depth=1 it appears right after the accepting edge, which matches a one-cycle delay.
- Throughput is one command per cycle while `out_ready` stays high.
- Full pipeline (`count == depth`) with `out_ready = 0`: `in_ready` = 0. Raising `out_ready` gives `in_ready` = 1 in the same cycle, so a simultaneous input and output transfer keeps `count` unchanged.
- Empty pipeline: `out_valid` = 0 and `*_out` hold their last values.
- Reset asserted mid-stream: all commands are discarded immediately, without waiting for an edge.

## Configuration
- `DECODE_DENSE_PIPE_COUNT_EN`:
  - Defined: `count` is a registered up/down counter. It adds 1 on input accept and subtracts 1 on output transfer, both in the same cycle leaves it unchanged, it is zeroed by `flush` and reset, and it is checked against popcount(`v`) by an in-block assertion.
  - Not defined: `count` is tied to 0 and no counter logic is built.

## Test plan
- Streaming: depth=2, reset, then 10 back-to-back commands with `x` = 1..10 and `out_ready` = 1. Required: `x_out` = 1 appears after the second edge, then one command per cycle in order, and `in_ready` stays 1.
- Backpressure: depth=3, `out_ready` = 0, push 4 commands. Required: 3 accepted, `in_ready` = 0, `count` = 3 (macro defined), `*_out` stable for 5 idle cycles. Then `out_ready` = 1 drains them in order.
- Bubble collapse: depth=3, push A, wait 2 idle cycles, push B with `out_ready` = 0. Required: A and B occupy adjacent stages, and the pipeline accepts a third command C.
- Simultaneous in/out when full: depth=2, full, then `in_valid` = 1 and `out_ready` = 1 for 4 cycles. Required: 4 transfers each way and `count` stays at 2.
- Flush: 2 commands in flight, `flush` = 1 with `in_valid` = 1. Required: `out_valid` = 0 and `count` = 0 after the edge, the input is not accepted, and the next command arrives with the normal latency.
- Async reset: assert `rst` between edges with the pipeline full. Required: `out_valid`, `*_out` and `count` reach 0 before the next edge.
